// File: rtl/round_controller.sv
// Round sequencer for the two-player fighting game: collects one action per
// player, issues a fixed-length actionEnable pulse, then judges both healths.
module round_controller #(
  parameter int TIMEOUT    = 50,
  parameter int ENABLE_LEN = 2,
  parameter int GAP        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sel1,
  input  logic       go1,
  input  logic [2:0] sel2,
  input  logic       go2,
  input  logic [1:0] health1,
  input  logic [1:0] health2,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       isGameOver,
  output logic [1:0] winner,
  output logic       has1,
  output logic       has2,
  output logic [7:0] roundCount
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ENABLE  = 2'd1,
    S_SETTLE  = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  localparam logic [2:0] ACT_AWAIT = 3'b010;
  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_P1    = 2'b01;
  localparam logic [1:0] WIN_P2    = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  localparam int TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int PMAX = (ENABLE_LEN > GAP) ? ENABLE_LEN : GAP;
  localparam int PW   = (PMAX < 2) ? 1 : $clog2(PMAX + 1);

  localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT);
  localparam logic [PW-1:0] EN_LAST  = PW'(ENABLE_LEN - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP - 1);

  state_t          state_reg, state_next;
  logic [1:0]      go_prev_reg;
  logic [1:0][2:0] action_reg, action_next;
  logic [1:0]      has_reg, has_next;
  logic [TW-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic [PW-1:0]   phase_reg, phase_next;
  logic            enable_reg, enable_next;
  logic            over_reg, over_next;
  logic [1:0]      winner_reg, winner_next;
  logic [7:0]      round_reg, round_next;

  logic [1:0]      go_vec;
  logic [1:0]      go_edge;
  logic [1:0]      take_sel;
  logic [1:0][2:0] sel_vec;

  assign go_vec  = {go2, go1};
  assign sel_vec = {sel2, sel1};

  // Per-player submit detection: a rising go edge only counts for a player
  // that has not yet submitted this round.
  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    assign go_edge[gi]  = go_vec[gi] & ~go_prev_reg[gi];
    assign take_sel[gi] = go_edge[gi] & ~has_reg[gi];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_COLLECT;
      go_prev_reg <= 2'b11;
      action_reg  <= {ACT_AWAIT, ACT_AWAIT};
      has_reg     <= 2'b00;
      tmo_cnt_reg <= '0;
      phase_reg   <= '0;
      enable_reg  <= 1'b0;
      over_reg    <= 1'b0;
      winner_reg  <= WIN_NONE;
      round_reg   <= 8'd0;
    end else begin
      state_reg   <= state_next;
      go_prev_reg <= go_vec;
      action_reg  <= action_next;
      has_reg     <= has_next;
      tmo_cnt_reg <= tmo_cnt_next;
      phase_reg   <= phase_next;
      enable_reg  <= enable_next;
      over_reg    <= over_next;
      winner_reg  <= winner_next;
      round_reg   <= round_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    action_next  = action_reg;
    has_next     = has_reg;
    tmo_cnt_next = tmo_cnt_reg;
    phase_next   = phase_reg;
    winner_next  = winner_reg;
    round_next   = round_reg;

    case (state_reg)
      S_COLLECT: begin
        if (&has_reg) begin
          state_next = S_ENABLE;
          phase_next = '0;
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (take_sel[i]) begin
              action_next[i] = sel_vec[i];
              has_next[i]    = 1'b1;
            end
          end
          // A real submission arriving on the terminal cycle beats the forced await.
          if ((^has_reg) && !(&has_next)) begin
            tmo_cnt_next = tmo_cnt_reg + TW'(1);
            if (tmo_cnt_next == TMO_END) begin
              for (int i = 0; i < 2; i++) begin
                if (!has_reg[i]) begin
                  action_next[i] = ACT_AWAIT;
                  has_next[i]    = 1'b1;
                end
              end
              state_next = S_ENABLE;
              phase_next = '0;
            end
          end
        end
      end

      S_ENABLE: begin
        if (phase_reg == EN_LAST) begin
          state_next = S_SETTLE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end

      S_SETTLE: begin
        if (phase_reg == GAP_LAST) begin
          phase_next = '0;
          if (health1 == 2'b00 && health2 == 2'b00) begin
            state_next  = S_OVER;
            winner_next = WIN_DRAW;
          end else if (health1 == 2'b00) begin
            state_next  = S_OVER;
            winner_next = WIN_P2;
          end else if (health2 == 2'b00) begin
            state_next  = S_OVER;
            winner_next = WIN_P1;
          end else begin
            state_next   = S_COLLECT;
            round_next   = round_reg + 8'd1;
            has_next     = 2'b00;
            tmo_cnt_next = '0;
          end
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end

      S_OVER: begin
        state_next = S_OVER;
      end

      default: begin
        state_next = S_COLLECT;
      end
    endcase
  end

  // Strobes are registered from the next state so they never glitch.
  assign enable_next = (state_next == S_ENABLE);
  assign over_next   = (state_next == S_OVER);

  assign action1      = action_reg[0];
  assign action2      = action_reg[1];
  assign has1         = has_reg[0];
  assign has2         = has_reg[1];
  assign actionEnable = enable_reg;
  assign isGameOver   = over_reg;
  assign winner       = winner_reg;
  assign roundCount   = round_reg;

endmodule
